ram_frame_seq: RTL
==================

RAM_FRAME_SEQ -- requirements
Module: ram_frame_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports named clock and reset_n.
REQ-002 Parameter WIDTH, default 8, SHALL set the data word width in bits.
REQ-003 Parameter ADDR_BITS, default 4, SHALL set the RAM address width; DEPTH = 2**ADDR_BITS.
REQ-004 Ports SHALL be:
- clock  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  block accepts a word this cycle
- in_data  input  WIDTH  upstream word
- in_last  input  1  word is last of frame
- out_valid  output  1  downstream word valid
- out_ready  input  1  downstream accepts word
- out_data  output  WIDTH  drained word
- out_last  output  1  drained word is last of frame
- ram_we  output  1  single-port RAM write enable
- ram_addr  output  ADDR_BITS  RAM address, shared by read and write
- ram_data  output  WIDTH  RAM write data
- ram_q  input  WIDTH  RAM read data; 1-cycle latency from ram_addr
- frame_len  output  ADDR_BITS+1  length of the current/last captured frame
- busy  output  1  high when the state is not FILL

Function
REQ-005 The FSM SHALL have three states: FILL, PRIME and DRAIN.
REQ-006 In FILL, in_ready SHALL be 1, and ram_we SHALL be 1 combinationally only when in_valid=1.
REQ-007 On each FILL handshake: ram_addr=wr_ptr, ram_data=in_data, and wr_ptr SHALL increment.
REQ-008 FILL->PRIME SHALL occur on a handshake with in_last=1, or with wr_ptr=DEPTH-1 (full) regardless of in_last; frame_len SHALL load wr_ptr+1 at that edge.
REQ-009 After a full-terminated frame, the next accepted word SHALL start a new frame; no word is dropped or merged.
REQ-010 In PRIME, in_ready=0, ram_we=0, ram_addr=0 and rd_ptr<=0; the next state SHALL be DRAIN unconditionally.
REQ-011 In DRAIN, out_valid SHALL be 1 and out_data SHALL be ram_q; out_last SHALL be 1 only when rd_ptr=frame_len-1.
REQ-012 In DRAIN, ram_addr SHALL be rd_ptr+1 when out_ready=1 and rd_ptr otherwise, so out_data remains stable across stalls.
REQ-013 On each DRAIN handshake rd_ptr SHALL increment; on the out_last handshake the state SHALL return to FILL with wr_ptr<=0.
REQ-014 Latency: the first out_valid SHALL occur exactly 2 cycles after the edge on which the terminating FILL handshake is accepted.
REQ-015 in_valid SHALL be ignored outside FILL; ram_we SHALL never be 1 outside FILL.
REQ-016 A frame of length 1 (in_last on the first word) SHALL drain one word with out_last=1.
REQ-017 out_valid SHALL be 0 in FILL and PRIME.

Reset
REQ-018 When reset_n=0 at a rising edge: state<=FILL, wr_ptr<=0, rd_ptr<=0, frame_len<=0; outputs then SHALL be out_valid=0, out_last=0, ram_we=0 (until in_valid), busy=0, in_ready=1.
REQ-019 A reset during PRIME or DRAIN SHALL abort the frame; undrained words are discarded and no further out_valid occurs for them.

Configuration
REQ-020 Macro RAM_FRAME_SEQ_FRAME_CNT_EN, when defined, SHALL add output frame_cnt (8 bits), reset to 0, incremented on each out_last handshake and wrapping 255->0.
REQ-021 Without RAM_FRAME_SEQ_FRAME_CNT_EN, the frame_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-022 Write 0x11,0x22,0x33 with in_last on 0x33, out_ready=1 -> out_valid 2 cycles later; outputs 0x11,0x22,0x33 on consecutive cycles; out_last on 0x33; frame_len=3.
REQ-023 Write 16 words 0x00..0x0F with in_last=0 -> frame ends at address 15; frame_len=16; drain 0x00..0x0F with out_last on 0x0F; the 17th word lands at address 0 of the next frame.
REQ-024 Frame 0xA5 (length 1), out_ready=0 for 5 DRAIN cycles -> out_data holds 0xA5 with out_valid=1; out_last=1; FILL resumes one cycle after out_ready=1.
REQ-025 Random out_ready toggling on an 8-word frame -> no duplicate or skipped word; ram_we=0 and in_ready=0 throughout PRIME/DRAIN.
REQ-026 reset_n=0 for one cycle mid-DRAIN (after 2 of 5 words) -> next cycle: out_valid=0, busy=0, in_ready=1; a new 2-word frame then drains correctly.
REQ-027 With RAM_FRAME_SEQ_FRAME_CNT_EN defined, 257 one-word frames -> frame_cnt=1.

Source files
------------

// File: rtl/ram_frame_seq.sv
// Frame sequencer over an external single-port RAM: captures a frame, then replays it in order.
// Optional frame counter output enabled by defining RAM_FRAME_SEQ_FRAME_CNT_EN.
module ram_frame_seq #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [WIDTH-1:0]     ram_data,
  input  logic [WIDTH-1:0]     ram_q,
  output logic [ADDR_BITS:0]   frame_len,
  output logic                 busy
`ifdef RAM_FRAME_SEQ_FRAME_CNT_EN
  ,
  output logic [7:0]           frame_cnt
`endif
);

  typedef enum logic [1:0] {FILL, PRIME, DRAIN} state_e;

  localparam logic [ADDR_BITS-1:0] PTR_MAX = '1;
  localparam logic [ADDR_BITS-1:0] PTR_ONE = 1;
  localparam logic [ADDR_BITS:0]   LEN_ONE = 1;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   frame_len_q, frame_len_d;
  logic [ADDR_BITS:0]   last_idx;
  logic                 wr_full;
  logic                 is_last;

  assign wr_full   = (wr_ptr_q == PTR_MAX);
  assign last_idx  = frame_len_q - LEN_ONE;
  assign is_last   = ({1'b0, rd_ptr_q} == last_idx);
  assign busy      = (state_q != FILL);
  assign frame_len = frame_len_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    frame_len_d = frame_len_q;
    in_ready    = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_data    = in_data;
    out_valid   = 1'b0;
    out_data    = ram_q;
    out_last    = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        ram_we   = in_valid;
        ram_addr = wr_ptr_q;
        if (in_valid) begin
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (in_last || wr_full) begin
            state_d     = PRIME;
            frame_len_d = {1'b0, wr_ptr_q} + LEN_ONE;
          end
        end
      end
      PRIME: begin
        ram_addr = '0;
        rd_ptr_d = '0;
        state_d  = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = is_last;
        // Prefetch the next word only when the current one is taken, so ram_q holds during stalls.
        ram_addr  = out_ready ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        if (out_ready) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          if (is_last) begin
            state_d  = FILL;
            wr_ptr_d = '0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_len_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_len_q <= frame_len_d;
    end
  end

`ifdef RAM_FRAME_SEQ_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else if (state_q == DRAIN && out_ready && is_last) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule
